johnson_rx: RTL and testbench

Receive-side checker for the 8-bit twisted-ring (Johnson) code that the tile's ring counter drives off-chip. It samples one code word per strobe, decodes the word to a 4-bit phase, and locks onto the 16-state sequence. Once locked it flags and counts sequence errors. It sits behind the dedicated inputs (`ui_in`) of a second tile, or in loopback on the same tile, and reports lock, phase and error status to the output pins.

---
 rtl/johnson_pkg.sv | 27 ++
 rtl/johnson_rx_phase_dec.sv | 38 +++
 rtl/johnson_rx.sv | 172 +++++++++++++++++
 tb/tb_johnson_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson (twisted-ring) code receiver.
//   - FSM state encoding for the lock tracker
//   - code width / phase count constants
//   - reference code table and the generator step function
package johnson_pkg;

  localparam int JW      = 8;
  localparam int JPHASES = 16;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } johnson_state_e;

  // Code word for each phase 0..15, in sequence order.
  localparam logic [JW-1:0] JCODE [JPHASES] = '{
    8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
    8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
  };

  // One step of the twisted-ring generator: shift left, feed back inverted MSB.
  function automatic logic [JW-1:0] johnson_next(input logic [JW-1:0] q);
    return {q[JW-2:0], ~q[JW-1]};
  endfunction

endpackage

// File: rtl/johnson_rx_phase_dec.sv
// johnson_phase_dec: combinational decode of an 8-bit Johnson word.
// Ports:
//   code_in [7:0] in  : candidate code word
//   legal         out : code_in is one of the 16 sequence words
//   phase   [3:0] out : decoded phase (0 when illegal)
// A word with k ones packed at the LSB end is phase k (0..8); a word with
// k ones packed at the MSB end (k = 1..7) is phase 16-k.
module johnson_phase_dec
  import johnson_pkg::*;
(
  input  logic [JW-1:0] code_in,
  output logic          legal,
  output logic [3:0]    phase
);

  // Compare the word against both thermometer forms for every ones count.
  always_comb begin
    legal = 1'b0;
    phase = 4'd0;
    for (int k = 0; k <= JW; k++) begin
      if (code_in == 8'(9'h0FF >> (JW - k))) begin
        legal = 1'b1;
        phase = 4'(k);
      end else begin
        legal = legal;
      end
    end
    for (int k = 1; k < JW; k++) begin
      if (code_in == ~(8'hFF >> k)) begin
        legal = 1'b1;
        phase = 4'(JPHASES - k);
      end else begin
        legal = legal;
      end
    end
  end

endmodule

// File: rtl/johnson_rx.sv
// johnson_rx: samples Johnson code words, decodes phase, locks onto the
// 16-state sequence and counts sequence errors once locked.
// Ports:
//   clk, rst_n (sync, active-low)
//   ena            : block enable; when low strobes are ignored, state holds
//   code_valid     : sample strobe for code_in
//   code_in [7:0]  : Johnson code word
//   err_clr        : synchronous clear of err_count (works with ena low)
//   phase [3:0]    : phase of the last legal accepted sample
//   phase_valid    : pulse, last accepted sample was legal
//   locked         : tracker is in LOCKED
//   err_pulse      : pulse, sequence error while LOCKED
//   err_count[7:0] : saturating error count
// All outputs are registered; an accepted sample in cycle N shows in N+1.
module johnson_rx
  import johnson_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int MAX_MISS   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          code_valid,
  input  logic [JW-1:0] code_in,
  input  logic          err_clr,
  output logic [3:0]    phase,
  output logic          phase_valid,
  output logic          locked,
  output logic          err_pulse,
  output logic [7:0]    err_count
);

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_COUNT);
  localparam logic [2:0] MAX_MISS_C = 3'(MAX_MISS);

  johnson_state_e state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] run_q, run_d;
  logic [2:0] miss_q, miss_d;
  logic [3:0] phase_q, phase_d;
  logic       phase_valid_q, phase_valid_d;
  logic       locked_q, locked_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_count_q, err_count_d;

  logic       accept_s;
  logic       dec_legal_s;
  logic [3:0] dec_phase_s;
  logic       seq_err_s;

  johnson_phase_dec u_dec (
    .code_in (code_in),
    .legal   (dec_legal_s),
    .phase   (dec_phase_s)
  );

  assign accept_s = ena & code_valid;

  // Lock tracker next state, phase capture and error counting.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    run_d         = run_q;
    miss_d        = miss_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    seq_err_s     = 1'b0;

    if (accept_s) begin
      if (dec_legal_s) begin
        phase_d       = dec_phase_s;
        phase_valid_d = 1'b1;
      end else begin
        phase_d = phase_q;
      end

      case (state_q)
        ST_HUNT: begin
          if (dec_legal_s) begin
            exp_d   = dec_phase_s + 4'd1;
            run_d   = 4'd0;
            state_d = ST_ACQUIRE;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_ACQUIRE: begin
          if (!dec_legal_s) begin
            state_d = ST_HUNT;
          end else if (dec_phase_s == exp_q) begin
            run_d = run_q + 4'd1;
            exp_d = exp_q + 4'd1;
            if (run_q + 4'd1 == LOCK_CNT_C) begin
              state_d = ST_LOCKED;
              miss_d  = 3'd0;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            run_d = 4'd0;
            exp_d = dec_phase_s + 4'd1;
          end
        end
        ST_LOCKED: begin
          // Flywheel: expectation advances on every accepted sample.
          exp_d = exp_q + 4'd1;
          if (dec_legal_s && (dec_phase_s == exp_q)) begin
            miss_d = 3'd0;
          end else begin
            seq_err_s = 1'b1;
            miss_d    = miss_q + 3'd1;
            if (miss_q + 3'd1 == MAX_MISS_C) begin
              state_d = ST_HUNT;
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    err_pulse_d = seq_err_s;
    locked_d    = (state_d == ST_LOCKED);

    // Clear wins over a same-cycle error; count saturates at 255.
    if (err_clr) begin
      err_count_d = 8'd0;
    end else if (seq_err_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      exp_q         <= 4'd0;
      run_q         <= 4'd0;
      miss_q        <= 3'd0;
      phase_q       <= 4'd0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      run_q         <= run_d;
      miss_q        <= miss_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      err_count_q   <= err_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_rx.sv
// Directed self-checking bench for johnson_rx (LOCK_COUNT=4, MAX_MISS=2).
module tb_johnson_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       code_valid;
  logic [7:0] code_in;
  logic       err_clr;
  logic [3:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-written reference table, phase index -> code word.
  logic [7:0] jt [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                          8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  johnson_rx #(.LOCK_COUNT(4), .MAX_MISS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .code_valid  (code_valid),
    .code_in     (code_in),
    .err_clr     (err_clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Present one word with the given strobe, clock it, sample 1ns after the edge.
  task automatic step(input logic [7:0] code, input logic v);
    code_in    = code;
    code_valid = v;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  logic [3:0] bexp;

  initial begin
    rst_n = 1'b0; ena = 1'b1; code_valid = 1'b0; code_in = 8'h00; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_pv", phase_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_errp", err_pulse, 0);
    check("rst_errc", err_count, 0);
    rst_n = 1'b1;

    // Acquire and lock on phases 0..4.
    for (int p = 0; p < 5; p++) begin
      step(jt[p], 1'b1);
      check("acq_pv", phase_valid, 1);
      check("acq_phase", phase, p);
      check("acq_locked", locked, (p == 4) ? 1 : 0);
    end

    // One bad word then flywheel-correct 3F.
    step(8'h5A, 1'b1);
    check("bad1_errp", err_pulse, 1);
    check("bad1_errc", err_count, 1);
    check("bad1_locked", locked, 1);
    check("bad1_pv", phase_valid, 0);
    step(8'h3F, 1'b1);
    check("fly_errp", err_pulse, 0);
    check("fly_phase", phase, 6);
    check("fly_locked", locked, 1);

    // Two consecutive illegal words drop lock.
    step(8'h7F, 1'b1);
    check("p7_errp", err_pulse, 0);
    step(8'h5A, 1'b1);
    check("miss1_errc", err_count, 2);
    check("miss1_locked", locked, 1);
    step(8'h5A, 1'b1);
    check("miss2_errc", err_count, 3);
    check("miss2_locked", locked, 0);
    step(8'h00, 1'b1);
    check("hunt_pv", phase_valid, 1);
    check("hunt_errp", err_pulse, 0);
    check("hunt_errc", err_count, 3);
    check("hunt_locked", locked, 0);

    // Relock on phases 8..12 (8 is a mismatch in ACQUIRE, restarts the run).
    for (int p = 8; p <= 12; p++) begin
      step(jt[p], 1'b1);
      check("relock_errp", err_pulse, 0);
      check("relock_locked", locked, (p == 12) ? 1 : 0);
    end

    // Wrap 13,14,15,0,1 while locked.
    for (int i = 13; i <= 17; i++) begin
      step(jt[i % 16], 1'b1);
      check("wrap_errp", err_pulse, 0);
      check("wrap_phase", phase, i % 16);
      check("wrap_locked", locked, 1);
    end
    check("wrap_errc", err_count, 3);

    // 300 more errors across relocks: count saturates.
    for (int r = 0; r < 150; r++) begin
      step(8'h5A, 1'b1);
      step(8'h5A, 1'b1);
      for (int p = 0; p < 5; p++) step(jt[p], 1'b1);
    end
    check("sat_errc", err_count, 255);
    check("sat_locked", locked, 1);

    // Clear together with an error.
    err_clr = 1'b1;
    step(8'h5A, 1'b1);
    err_clr = 1'b0;
    check("clr_errc", err_count, 0);
    check("clr_errp", err_pulse, 1);
    check("clr_locked", locked, 1);

    // Build err_count = 7 while staying locked (bad/good alternation).
    step(jt[6], 1'b1);
    check("good6_errp", err_pulse, 0);
    bexp = 4'd7;
    for (int i = 0; i < 6; i++) begin
      step(8'h5A, 1'b1);
      bexp = bexp + 4'd1;
      step(jt[bexp], 1'b1);
      bexp = bexp + 4'd1;
    end
    step(8'h5A, 1'b1);
    check("e7_errc", err_count, 7);
    check("e7_locked", locked, 1);

    // Reset mid-operation with a strobe present.
    rst_n = 1'b0;
    step(jt[bexp], 1'b1);
    rst_n = 1'b1;
    check("mrst_phase", phase, 0);
    check("mrst_pv", phase_valid, 0);
    check("mrst_locked", locked, 0);
    check("mrst_errp", err_pulse, 0);
    check("mrst_errc", err_count, 0);

    // Strobes with ena low are ignored.
    ena = 1'b0;
    step(8'h01, 1'b1);
    step(8'h03, 1'b1);
    check("ena0_pv", phase_valid, 0);
    check("ena0_phase", phase, 0);
    ena = 1'b1;

    // From HUNT: 1,2,3,4 -> not locked yet, 5 -> locked.
    for (int p = 1; p <= 5; p++) begin
      step(jt[p], 1'b1);
      check("h_phase", phase, p);
      check("h_locked", locked, (p == 5) ? 1 : 0);
    end

    // Freeze mid-sequence, then resume with expected phase 6.
    ena = 1'b0;
    step(8'h5A, 1'b1);
    step(8'h00, 1'b1);
    check("frz_errp", err_pulse, 0);
    check("frz_phase", phase, 5);
    check("frz_locked", locked, 1);
    ena = 1'b1;
    step(8'h3F, 1'b1);
    check("resume_errp", err_pulse, 0);
    check("resume_phase", phase, 6);

    // err_clr honoured with ena low.
    step(8'h5A, 1'b1);
    check("pre_clr_errc", err_count, 1);
    ena = 1'b0;
    err_clr = 1'b1;
    step(8'h00, 1'b0);
    err_clr = 1'b0;
    check("ena0_clr_errc", err_count, 0);
    check("ena0_clr_locked", locked, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
